// File: rtl/rom_seq_ctrl.sv
// Program-ROM sequencer: owns the ROM address, absorbs read latency and strobes each word out.
// Optional ping-pong addressing when ROM_SEQ_BOUNCE_EN is defined; default build wraps LAST->FIRST.
module rom_seq_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ROM_LAT = 2,
  parameter int unsigned FIRST   = 0,
  parameter int unsigned LAST    = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run,
  input  logic              step,
  input  logic              rewind,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST);
  localparam logic [2:0]        LatCnt    = 3'(ROM_LAT);

  typedef enum logic [0:0] {StFetch, StShow} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                busy_q, busy_d;
  logic                advance;
  logic                fetch_done;
  logic [ADDR_W-1:0]   next_pc;

`ifdef ROM_SEQ_BOUNCE_EN
  logic dir_up_q, dir_up_d, next_dir_up;

  always_comb begin
    next_pc     = pc_q;
    next_dir_up = dir_up_q;
    if (FirstAddr == LastAddr) begin
      next_pc = FirstAddr;
    end else if (dir_up_q) begin
      if (pc_q == LastAddr) begin
        next_pc     = LastAddr - 1'b1;
        next_dir_up = 1'b0;
      end else begin
        next_pc = pc_q + 1'b1;
      end
    end else begin
      if (pc_q == FirstAddr) begin
        next_pc     = FirstAddr + 1'b1;
        next_dir_up = 1'b1;
      end else begin
        next_pc = pc_q - 1'b1;
      end
    end
  end
`else
  assign next_pc = (pc_q == LastAddr) ? FirstAddr : pc_q + 1'b1;
`endif

  // Strobes arriving while a fetch is outstanding are dropped, never queued.
  assign advance    = (state_q == StShow) && (run ? tick : step);
  assign fetch_done = (state_q == StFetch) && ((cnt_q + 3'd1) == LatCnt);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
`ifdef ROM_SEQ_BOUNCE_EN
    dir_up_d     = dir_up_q;
`endif
    if (rewind) begin
      // Aborts any outstanding fetch; the abandoned word is never shown.
      state_d = StFetch;
      cnt_d   = 3'd0;
      pc_d    = FirstAddr;
`ifdef ROM_SEQ_BOUNCE_EN
      dir_up_d = 1'b1;
`endif
    end else if (state_q == StFetch) begin
      if (fetch_done) begin
        state_d      = StShow;
        cnt_d        = 3'd0;
        disp_data_d  = rom_q;
        disp_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else if (advance) begin
      state_d = StFetch;
      cnt_d   = 3'd0;
      pc_d    = next_pc;
`ifdef ROM_SEQ_BOUNCE_EN
      dir_up_d = next_dir_up;
`endif
    end
    busy_d = (state_d == StFetch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      cnt_q        <= 3'd0;
      pc_q         <= FirstAddr;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ROM_SEQ_BOUNCE_EN
      dir_up_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
`ifdef ROM_SEQ_BOUNCE_EN
      dir_up_q     <= dir_up_d;
`endif
    end
  end

  assign rom_addr   = pc_q;
  assign pc         = pc_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Bench for rom_seq_ctrl: directed scenarios plus random strobes against a schedule-based model.
// Define ROM_SEQ_BOUNCE_EN to exercise ping-pong addressing on window 2..4.
module tb_rom_seq_ctrl;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ROM_LAT = 2;
`ifdef ROM_SEQ_BOUNCE_EN
  localparam int unsigned FIRST   = 2;
  localparam int unsigned LAST    = 4;
  localparam bit          BOUNCE  = 1'b1;
`else
  localparam int unsigned FIRST   = 0;
  localparam int unsigned LAST    = 15;
  localparam bit          BOUNCE  = 1'b0;
`endif

  logic              clk, rst, tick, run, step, rewind;
  logic [ADDR_W-1:0] rom_addr, pc;
  logic [DATA_W-1:0] rom_q, disp_data;
  logic              disp_valid, busy;

  rom_seq_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ROM_LAT(ROM_LAT),
    .FIRST  (FIRST),
    .LAST   (LAST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .run       (run),
    .step      (step),
    .rewind    (rewind),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pc        (pc),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return 16'hA000 + 16'(a);
  endfunction

  // Registered-address ROM: one address register, output sampled one edge later.
  logic [ADDR_W-1:0] rom_stage;
  always @(posedge clk) rom_stage <= rom_addr;
  assign rom_q = word(rom_stage);

  int errors = 0;
  int checks = 0;

  // Model: count of advances since reset/rewind, mapped to an address arithmetically.
  int                cyc = 0;
  int                m_idx = 0;
  int                m_due = -1;
  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_disp;
  logic              m_valid, m_busy;

  logic [ADDR_W-1:0] pulse_pcs[$];
  logic [DATA_W-1:0] pulse_data[$];

  function automatic logic [ADDR_W-1:0] idx_to_pc(input int idx);
    int span, per, r;
    span = int'(LAST) - int'(FIRST);
    if (!BOUNCE) return ADDR_W'(int'(FIRST) + idx % (span + 1));
    if (span == 0) return ADDR_W'(FIRST);
    per = 2 * span;
    r   = idx % per;
    return ADDR_W'(int'(FIRST) + ((r <= span) ? r : per - r));
  endfunction

  task automatic model_edge();
    cyc++;
    if (rst) begin
      m_idx   = 0;
      m_due   = cyc + ROM_LAT;
      m_disp  = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (rewind) begin
        m_idx  = 0;
        m_due  = cyc + ROM_LAT;
        m_busy = 1'b1;
      end else if (m_due >= 0) begin
        if (cyc == m_due) begin
          m_disp  = word(idx_to_pc(m_idx));
          m_valid = 1'b1;
          m_due   = -1;
          m_busy  = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end else if (run ? tick : step) begin
        m_idx++;
        m_due  = cyc + ROM_LAT;
        m_busy = 1'b1;
      end
    end
    m_pc = idx_to_pc(m_idx);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("disp_valid", disp_valid, m_valid);
    chk("disp_data", disp_data, m_disp);
    chk("pc", pc, m_pc);
    chk("rom_addr", rom_addr, m_pc);
    chk("busy", busy, m_busy);
    if (disp_valid) begin
      pulse_pcs.push_back(pc);
      pulse_data.push_back(disp_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  logic [ADDR_W-1:0] bounce_seq[8];
  int                n_run;
  logic [ADDR_W-1:0] after_run, step_a, step_b, dropped_pc, rw_target;

  initial begin
    bounce_seq = '{4'd3, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2};
    n_run      = BOUNCE ? 8 : 17;
    after_run  = BOUNCE ? 4'd2 : 4'd1;
    step_a     = BOUNCE ? 4'd3 : 4'd2;
    step_b     = BOUNCE ? 4'd4 : 4'd3;
    dropped_pc = BOUNCE ? 4'd3 : 4'd4;
    rw_target  = BOUNCE ? 4'd3 : 4'd5;

    rst = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0; rewind = 1'b0;
    idle(3);
    chk("reset_pc", pc, FIRST);
    chk("reset_valid", disp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", disp_data, 0);

    // First word loads without any tick, ROM_LAT cycles after release.
    rst = 1'b0;
    cycle();
    chk("post_reset_early", disp_valid, 0);
    cycle();
    chk("post_reset_valid", disp_valid, 1);
    chk("post_reset_data", disp_data, 16'hA000 + FIRST);
    chk("post_reset_pc", pc, FIRST);
    cycle();
    chk("post_reset_busy", busy, 0);

    // Run mode: one displayed word per tick, wrapping or bouncing.
    pulse_pcs.delete();
    pulse_data.delete();
    run = 1'b1;
    for (int k = 0; k < n_run; k++) begin
      pulse_tick();
      idle(7);
    end
    chk("run_pulse_count", pulse_pcs.size(), n_run);
    for (int k = 0; k < n_run && k < pulse_pcs.size(); k++) begin
      chk("run_pc_seq", pulse_pcs[k], BOUNCE ? bounce_seq[k] : 4'((k + 1) % 16));
      chk("run_data_seq", pulse_data[k], 16'hA000 + 16'(BOUNCE ? bounce_seq[k] : 4'((k + 1) % 16)));
    end

    // Step mode: ticks ignored, each step advances once.
    run = 1'b0;
    pulse_pcs.delete();
    for (int k = 0; k < 5; k++) begin
      pulse_tick();
      idle(3);
    end
    chk("step_ticks_ignored", pulse_pcs.size(), 0);
    chk("step_pc_hold", pc, after_run);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      idle(5);
    end
    chk("step_pulse_count", pulse_pcs.size(), 2);
    if (pulse_pcs.size() == 2) begin
      chk("step_pc_a", pulse_pcs[0], step_a);
      chk("step_pc_b", pulse_pcs[1], step_b);
    end
    run = 1'b1;
    pulse_pcs.delete();
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      idle(5);
    end
    chk("step_with_run_ignored", pulse_pcs.size(), 0);
    chk("step_with_run_pc", pc, step_b);

    // A tick landing in FETCH is dropped.
    pulse_pcs.delete();
    tick = 1'b1;
    cycle();
    cycle();
    tick = 1'b0;
    idle(8);
    chk("dropped_pulse_count", pulse_pcs.size(), 1);
    chk("dropped_pc", pc, dropped_pc);

    // Rewind one cycle after an advance aborts that fetch.
    rewind = 1'b1;
    cycle();
    rewind = 1'b0;
    idle(4);
    for (int k = 0; k < (BOUNCE ? 0 : 4); k++) begin
      pulse_tick();
      idle(4);
    end
    pulse_tick();
    chk("rewind_target_pc", pc, rw_target);
    rewind = 1'b1;
    cycle();
    rewind = 1'b0;
    chk("rewind_pc", pc, FIRST);
    cycle();
    chk("rewind_abort_no_valid", disp_valid, 0);
    cycle();
    chk("rewind_valid", disp_valid, 1);
    chk("rewind_data", disp_data, 16'hA000 + FIRST);
    idle(3);

    // Random strobes, level changes, rewinds and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      tick   = ($urandom % 4) == 0;
      step   = ($urandom % 6) == 0;
      rewind = ($urandom % 50) == 0;
      rst    = ($urandom % 400) == 0;
      if (($urandom % 64) == 0) run = ~run;
      cycle();
    end
    tick = 1'b0; step = 1'b0; rewind = 1'b0; rst = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
